// File: rtl/output_port_arbiter_pkg.sv
// Shared types and constants for the router output-port arbiter.
// Covers the port count, port index, flit-type encoding and arbiter FSM states.
package output_port_arbiter_pkg;

  localparam int unsigned N_PORTS = 5;
  localparam int unsigned IDX_W   = 3;

  typedef logic [IDX_W-1:0] port_idx_t;

  // {head, tail} of the flit currently presented by a requester
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic flit_type_e flit_type(logic head, logic tail);
    return flit_type_e'({head, tail});
  endfunction

  // Round-robin successor of idx among n ports
  function automatic port_idx_t next_idx(port_idx_t idx, int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : IDX_W'(32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input routers and one output-port arbiter.
// master drives requests and buffer readiness; slave is the arbiter.
interface output_port_arbiter_if #(
  parameter int unsigned N_PORTS = output_port_arbiter_pkg::N_PORTS
);
  import output_port_arbiter_pkg::*;

  logic [N_PORTS-1:0] req_i;
  logic [N_PORTS-1:0] head_i;
  logic [N_PORTS-1:0] tail_i;
  logic               ready_i;
  logic [N_PORTS-1:0] grant_o;
  port_idx_t          owner_o;
  logic               busy_o;

  modport master (
    output req_i, head_i, tail_i, ready_i,
    input  grant_o, owner_o, busy_o
  );

  modport slave (
    input  req_i, head_i, tail_i, ready_i,
    output grant_o, owner_o, busy_o
  );

endinterface

// File: rtl/output_port_arbiter_rr_picker.sv
// Combinational masked round-robin priority encoder: first eligible port at or
// above rr_ptr, otherwise the lowest eligible port.
module rr_picker #(
  parameter int unsigned N_PORTS = output_port_arbiter_pkg::N_PORTS
) (
  input  logic [N_PORTS-1:0]                eligible,
  input  output_port_arbiter_pkg::port_idx_t rr_ptr,
  output logic [N_PORTS-1:0]                grant_c,
  output output_port_arbiter_pkg::port_idx_t idx_c,
  output logic                              valid_c
);
  import output_port_arbiter_pkg::*;

  logic found;

  always_comb begin
    found   = 1'b0;
    idx_c   = '0;
    grant_c = '0;
    // Upper (masked) half first, then wrap around to the low ports
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && eligible[i] && (i >= 32'(rr_ptr))) begin
        found = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && eligible[i]) begin
        found = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
    if (found) begin
      grant_c = N_PORTS'(1) << idx_c;
    end
    valid_c = found;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter for a wormhole router: round-robin over requesters.
// Define ARB_PKT_LOCK_EN for per-packet locking; default build arbitrates per flit.
module output_port_arbiter #(
  parameter int unsigned N_PORTS = output_port_arbiter_pkg::N_PORTS
) (
  input  logic                  clk,
  input  logic                  arst,
  output_port_arbiter_if.slave  bus
);
  import output_port_arbiter_pkg::*;

  arb_state_t         state_q, state_d;
  port_idx_t          rr_ptr_q, rr_ptr_d;
  port_idx_t          owner_q, owner_d;

  logic [N_PORTS-1:0] eligible_c;
  logic [N_PORTS-1:0] pick_grant_c;
  port_idx_t          pick_idx_c;
  logic               pick_valid_c;
  logic [N_PORTS-1:0] grant_c;

  rr_picker #(.N_PORTS(N_PORTS)) u_rr_picker (
    .eligible (eligible_c),
    .rr_ptr   (rr_ptr_q),
    .grant_c  (pick_grant_c),
    .idx_c    (pick_idx_c),
    .valid_c  (pick_valid_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef ARB_PKT_LOCK_EN
  logic [N_PORTS-1:0] owner_onehot_c;

  // Only head flits may open a packet; a locked port arbitrates nobody
  assign eligible_c     = (state_q == ST_IDLE) ? (bus.req_i & bus.head_i) : '0;
  assign owner_onehot_c = N_PORTS'(1) << owner_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_c  = '0;
    case (state_q)
      ST_IDLE: begin
        grant_c = pick_grant_c;
        if (pick_valid_c && bus.ready_i) begin
          owner_d  = pick_idx_c;
          rr_ptr_d = next_idx(pick_idx_c, N_PORTS);
          if (flit_type(bus.head_i[pick_idx_c], bus.tail_i[pick_idx_c]) != FLIT_SINGLE) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        // Owner bubble keeps the lock with no grant
        if (bus.req_i[owner_q]) begin
          grant_c = owner_onehot_c;
          if (bus.ready_i && bus.tail_i[owner_q]) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy_o = !arst && (state_q == ST_LOCKED);
`else
  logic unused_flit_bits;

  assign eligible_c       = bus.req_i;
  assign unused_flit_bits = ^{bus.head_i, bus.tail_i, state_q};

  always_comb begin
    state_d  = ST_IDLE;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_c  = pick_grant_c;
    if (pick_valid_c && bus.ready_i) begin
      owner_d  = pick_idx_c;
      rr_ptr_d = next_idx(pick_idx_c, N_PORTS);
    end
  end

  assign bus.busy_o = 1'b0;
`endif

  assign bus.grant_o = arst ? '0 : grant_c;
  assign bus.owner_o = owner_q;

endmodule
